// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - exhaustive truth-table sweep and compare engine for a gate DUT
// Optional early abort on first mismatch: TRUTH_TABLE_SCANNER_ABORT_EN
`timescale 1ns/1ps
module truth_table_scanner #(
  parameter int unsigned                N_INPUTS = 4,
  parameter logic [(1<<N_INPUTS)-1:0]   EXPECTED = 16'h8000,
  parameter int unsigned                SETTLE   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_INPUTS-1:0] vec_out,
  input  logic                y_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic [N_INPUTS-1:0] first_err_idx
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam int unsigned                 DEPTH      = 1 << N_INPUTS;
  localparam logic [DEPTH-1:0]            L_TABLE    = EXPECTED;
  localparam logic [N_INPUTS-1:0]         L_LAST_VEC = '1;
  localparam logic [7:0]                  L_LAST_CNT = 8'(SETTLE - 1);
  localparam logic [N_INPUTS-1:0]         L_VEC_ONE  = N_INPUTS'(1);
  localparam logic [N_INPUTS:0]           L_ERR_ZERO = '0;

  logic [1:0]          r_state;
  logic [N_INPUTS-1:0] r_vec;
  logic [7:0]          r_cnt;
  logic [N_INPUTS:0]   r_err;
  logic [N_INPUTS-1:0] r_first;
  logic                r_pass;

  logic                w_sample;
  logic                w_mismatch;
  logic                w_last_vec;
  logic                w_end_scan;
  logic [N_INPUTS:0]   w_err_next;

  // The compare happens on the last cycle of each settle window
  assign w_sample   = (r_state == S_RUN) && (r_cnt == L_LAST_CNT);
  assign w_mismatch = w_sample && (y_in != L_TABLE[r_vec]);
  assign w_last_vec = (r_vec == L_LAST_VEC);
  assign w_err_next = r_err + {{N_INPUTS{1'b0}}, w_mismatch};

`ifdef TRUTH_TABLE_SCANNER_ABORT_EN
  assign w_end_scan = w_sample && (w_last_vec || w_mismatch);
`else
  assign w_end_scan = w_sample && w_last_vec;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_first <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_mismatch) begin
            r_err <= w_err_next;
            if (r_err == L_ERR_ZERO) r_first <= r_vec;
          end
          // vec_out is left untouched on the way out so it shows the last vector tested
          if (w_end_scan) begin
            r_state <= S_FINISH;
            r_pass  <= (w_err_next == L_ERR_ZERO);
          end else if (w_sample) begin
            r_vec <= r_vec + L_VEC_ONE;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign vec_out       = r_vec;
  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_FINISH);
  assign pass          = r_pass;
  assign err_count     = r_err;
  assign first_err_idx = r_first;

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Self-checking exhaustive stimulus engine for combinational gate blocks. It sweeps all 2^N_INPUTS input vectors into a device under test and samples its single output after a programmable settle time. Each sample is compared against a parameterised expected truth table, and the block reports pass/fail, the mismatch count and the first failing vector. It sits beside a gate instance in simulation or on-board self-test, replacing hand-written enumeration loops.

## Interface
Parameters:
- N_INPUTS, 4: DUT input count; legal range 1..16.
- EXPECTED, 16'h8000: expected truth table, 2^N_INPUTS bits. Bit k is the expected y for input vector k.
- SETTLE, 1: cycles each vector is held before y_in is sampled; legal range 1..255.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- start  in  1  begin a scan; sampled only in IDLE.
- vec_out  out  N_INPUTS  stimulus to DUT. Bit N_INPUTS-1 drives the first DUT input (a), bit 0 drives the last.
- y_in  in  1  DUT output under test.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when a scan completes or aborts.
- pass  out  1  last scan had zero mismatches; held until next start.
- err_count  out  N_INPUTS+1  mismatches in last or current scan.
- first_err_idx  out  N_INPUTS  vector index of first mismatch; valid only when err_count != 0.

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE, start=1: clear err_count, first_err_idx and pass; load vec_out=0 and settle counter=0; go to RUN. start=0: stay in IDLE.
- RUN: vec_out is held while the settle counter counts 0..SETTLE-1.
- At the edge where the counter equals SETTLE-1: compare y_in with EXPECTED[vec_out].
  - On mismatch: increment err_count. If err_count was 0, capture vec_out into first_err_idx.
  - If vec_out == 2^N_INPUTS-1, go to FINISH. Otherwise increment vec_out and clear the counter.
- FINISH (one cycle): done=1, busy=0, pass=(err_count==0); then go to IDLE.
- busy=1 in RUN only.
- start in RUN or FINISH is ignored; there is no queuing.
- vec_out holds its last value in IDLE and after FINISH.
- err_count cannot overflow: its maximum is 2^N_INPUTS, which fits in N_INPUTS+1 bits.
- EXPECTED bits above 2^N_INPUTS-1 are ignored.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0.
- Reset applies mid-scan too. The scan is discarded and no done pulse is generated.
- With start accepted at edge E0:
  - vec_out=0 and busy=1 from E0.
  - Vector k is presented during cycles E0+k*SETTLE .. E0+(k+1)*SETTLE-1 and sampled at the edge ending that window.
  - done and the final pass are visible in the cycle after edge E0+2^N_INPUTS*SETTLE.
- Total scan latency, start to done: 2^N_INPUTS*SETTLE+1 cycles.
- y_in is sampled registered; the DUT path must settle within SETTLE cycles.
- err_count updates one cycle after each failing sample edge and is observable while busy.

## Configuration
- Macro: TRUTH_TABLE_SCANNER_ABORT_EN.
- Defined: the first mismatch transitions RUN→FINISH at that sample edge.
  - Result: err_count=1 and first_err_idx = the failing vector.
  - done pulses early; vec_out freezes at the failing vector.
- Undefined: the full sweep always completes and err_count is the total mismatch count.

## Test plan
- N_INPUTS=4, SETTLE=1, DUT = 4-input AND, EXPECTED=16'h8000, start pulse → vec_out walks 0..15, done at cycle 17, pass=1, err_count=0.
- Same setup, DUT output stuck at 0 → pass=0, err_count=1, first_err_idx=15.
- DUT = NAND, EXPECTED=16'h8000 → err_count=16 (5'b10000), first_err_idx=0, pass=0.
- SETTLE=3, N_INPUTS=2, EXPECTED=4'b0110, DUT=XOR → each vector held exactly 3 cycles, done at cycle 13, pass=1; start pulses at cycles 2 and 5 are ignored.
- rst_n=0 at cycle 6 of a scan → next cycle all outputs 0, state IDLE, no done pulse; a new start runs a clean full scan.
- With TRUTH_TABLE_SCANNER_ABORT_EN, N_INPUTS=4, SETTLE=1, DUT = 4-input AND with output forced to 1 on vector 5, EXPECTED=16'h8000 → done at cycle 7, err_count=1, first_err_idx=5, vec_out frozen at 5.
